smfro_rng_ctrl: RTL and testbench

Sequencing controller for the 16-bit self-mutating feedback ring RNG core. It seeds the core and holds the core through a warm-up period. It then decimates the core's per-cycle output into sampled words, runs a repetition-count health test on each sample, and delivers accepted words to one consumer through a 2-entry valid/ready buffer. It sits between the RNG core and any block that consumes random words (key generation, nonce logic).

---
 rtl/smfro_rng_ctrl_if.sv | 19 +
 rtl/smfro_rng_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_smfro_rng_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/smfro_rng_ctrl_if.sv
// Consumer-side random word handshake for smfro_rng_ctrl.
// The controller drives data/valid as master; the consumer returns ready.
interface smfro_rng_ctrl_if;
    logic [15:0] rnd_data;
    logic        rnd_valid;
    logic        rnd_ready;

    modport master (
        output rnd_data,
        output rnd_valid,
        input  rnd_ready
    );

    modport slave (
        input  rnd_data,
        input  rnd_valid,
        output rnd_ready
    );
endinterface

// File: rtl/smfro_rng_ctrl.sv
// Sequencing controller for the 16-bit self-mutating feedback ring RNG:
// seed, warm-up, decimate, repetition-count test, 2-entry output buffer.
module smfro_rng_ctrl #(
    parameter int unsigned WARMUP    = 64,
    parameter int unsigned DECIM     = 4,
    parameter int unsigned REP_LIMIT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [15:0]        seed_i,
    input  logic               clr_fault_i,
    input  logic [15:0]        core_out_i,
    output logic               core_load_o,
    output logic [15:0]        core_seed_o,
    output logic               busy_o,
    output logic               fault_o,
    output logic [7:0]         drop_cnt_o,
    smfro_rng_ctrl_if.master   rnd
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WARM  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam logic [15:0] WARM_LAST = 16'(WARMUP - 1);
    localparam logic [7:0]  DEC_LAST  = 8'(DECIM - 1);
    localparam logic [7:0]  REP_MAX   = 8'(REP_LIMIT);
    localparam logic [15:0] SAFE_SEED = 16'hACE1;

    logic [2:0]  state_q, state_d;
    logic [15:0] seed_q, seed_d;
    logic        load_q, load_d;
    logic        busy_q, busy_d;
    logic        fault_q, fault_d;
    logic [15:0] warm_q, warm_d;
    logic [7:0]  dec_q, dec_d;
    logic [15:0] prev_q, prev_d;
    logic [7:0]  rep_q, rep_d;
    logic [15:0] head_q, head_d;
    logic [15:0] tail_q, tail_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic [7:0]  drop_q, drop_d;

    logic        pop;
    logic        tick;
    logic        ok;
    logic        push;
    logic        flush;
    logic [7:0]  rep_next;

    always_comb begin
        state_d  = state_q;
        seed_d   = seed_q;
        load_d   = 1'b0;
        warm_d   = warm_q;
        dec_d    = dec_q;
        prev_d   = prev_q;
        rep_d    = rep_q;
        ok       = 1'b0;
        flush    = 1'b0;
        tick     = (state_q == S_RUN) && (dec_q == DEC_LAST);
        rep_next = (core_out_i == prev_q) ? rep_q + 8'd1 : 8'd1;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    load_d  = 1'b1;
                    seed_d  = (seed_i == 16'd0) ? SAFE_SEED : seed_i;
                end
            end
            S_LOAD: begin
                state_d = S_WARM;
                warm_d  = WARM_LAST;
            end
            S_WARM: begin
                if (stop_i) begin
                    state_d = S_IDLE;
                end else if (warm_q == 16'd0) begin
                    state_d = S_RUN;
                    dec_d   = 8'd0;
                    prev_d  = 16'd0;
                    rep_d   = 8'd0;
                end else begin
                    warm_d = warm_q - 16'd1;
                end
            end
            S_RUN: begin
                // stop outranks a fault found in the same cycle
                if (stop_i) begin
                    state_d = S_IDLE;
                end else begin
                    dec_d = tick ? 8'd0 : dec_q + 8'd1;
                    if (tick) begin
                        prev_d = core_out_i;
                        rep_d  = rep_next;
                        if (rep_next >= REP_MAX) begin
                            state_d = S_FAULT;
                            flush   = 1'b1;
                        end else begin
                            ok = 1'b1;
                        end
                    end
                end
            end
            S_FAULT: begin
                if (clr_fault_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d  = (state_d != S_IDLE);
        fault_d = (state_d == S_FAULT);
    end

    always_comb begin
        pop    = valid_q & rnd.rnd_ready;
        push   = ok && ((cnt_q != 2'd2) || pop);
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        drop_d = drop_q;

        if (ok && !push && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        if (flush) begin
            cnt_d = 2'd0;
        end else if (push && pop) begin
            if (cnt_q == 2'd2) begin
                head_d = tail_q;
                tail_d = core_out_i;
            end else begin
                head_d = core_out_i;
            end
        end else if (pop) begin
            head_d = tail_q;
            cnt_d  = cnt_q - 2'd1;
        end else if (push) begin
            if (cnt_q == 2'd0) begin
                head_d = core_out_i;
            end else begin
                tail_d = core_out_i;
            end
            cnt_d = cnt_q + 2'd1;
        end

        valid_d = (cnt_d != 2'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            seed_q  <= 16'd0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
            warm_q  <= 16'd0;
            dec_q   <= 8'd0;
            prev_q  <= 16'd0;
            rep_q   <= 8'd0;
            head_q  <= 16'd0;
            tail_q  <= 16'd0;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
            drop_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
            warm_q  <= warm_d;
            dec_q   <= dec_d;
            prev_q  <= prev_d;
            rep_q   <= rep_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign core_load_o   = load_q;
    assign core_seed_o   = seed_q;
    assign busy_o        = busy_q;
    assign fault_o       = fault_q;
    assign drop_cnt_o    = drop_q;
    assign rnd.rnd_data  = head_q;
    assign rnd.rnd_valid = valid_q;

endmodule

// File: tb/tb_smfro_rng_ctrl.sv
// Directed-sequence bench for smfro_rng_ctrl with random core words
// and a timeline/queue reference model.
module tb_smfro_rng_ctrl;

    localparam int W = 4;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [15:0] seed;
    logic        clr_fault;
    logic [15:0] core_out;
    logic        core_load;
    logic [15:0] core_seed;
    logic        busy;
    logic        fault;
    logic [7:0]  drop_cnt;

    smfro_rng_ctrl_if ifc ();

    smfro_rng_ctrl #(
        .WARMUP    (W),
        .DECIM     (D),
        .REP_LIMIT (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .stop_i      (stop),
        .seed_i      (seed),
        .clr_fault_i (clr_fault),
        .core_out_i  (core_out),
        .core_load_o (core_load),
        .core_seed_o (core_seed),
        .busy_o      (busy),
        .fault_o     (fault),
        .drop_cnt_o  (drop_cnt),
        .rnd         (ifc)
    );

    always #5 clk = ~clk;

    int          nvec   = 0;
    int          miscmp = 0;
    int          cyc    = 0;
    int          t0;
    int          drops;
    bit          hold   = 1'b0;
    logic [15:0] cov [0:4095];
    logic [15:0] q [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        core_out = hold ? 16'hBEEF : 16'($urandom);
        cov[cyc] = core_out;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_load"},  {31'd0, core_load},      32'd0);
        chk({tag, "_seed"},  {16'd0, core_seed},      32'd0);
        chk({tag, "_data"},  {16'd0, ifc.rnd_data},   32'd0);
        chk({tag, "_valid"}, {31'd0, ifc.rnd_valid},  32'd0);
        chk({tag, "_busy"},  {31'd0, busy},           32'd0);
        chk({tag, "_fault"}, {31'd0, fault},          32'd0);
        chk({tag, "_drop"},  {24'd0, drop_cnt},       32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; seed = 16'd0;
        clr_fault = 1'b0; core_out = 16'd0; ifc.rnd_ready = 1'b0;
        repeat (3) step();
        chk_reset_outputs("por");
        rst = 1'b0;
        step();

        // nominal run, ignored start in RUN, then stop with one held word
        ifc.rnd_ready = 1'b1;
        seed = 16'h1234;
        start = 1'b1;
        t0 = cyc;
        for (int rel = 1; rel <= 12; rel++) begin
            bit ev;
            step();
            if (rel == 1) begin
                start = 1'b0;
                chk("nom_seed", {16'd0, core_seed}, 32'h1234);
                chk("nom_busy", {31'd0, busy}, 32'd1);
            end
            ev = (rel >= 2 + W + D) && (((rel - (2 + W + D)) % D) == 0);
            chk($sformatf("nom_load_%0d", rel), {31'd0, core_load},
                {31'd0, rel == 1});
            chk($sformatf("nom_valid_%0d", rel), {31'd0, ifc.rnd_valid},
                {31'd0, ev});
            if (ev)
                chk($sformatf("nom_data_%0d", rel), {16'd0, ifc.rnd_data},
                    {16'd0, cov[cyc - 1]});
            if (rel == 10) begin
                start = 1'b1;
                seed = 16'($urandom);
            end
            if (rel == 11) start = 1'b0;
            if (rel == 12) ifc.rnd_ready = 1'b0;
        end
        step();
        stop = 1'b1;
        chk("stop_pre_valid", {31'd0, ifc.rnd_valid}, 32'd1);
        step();
        stop = 1'b0;
        chk("stop_busy", {31'd0, busy}, 32'd0);
        chk("stop_valid", {31'd0, ifc.rnd_valid}, 32'd1);
        chk("stop_data", {16'd0, ifc.rnd_data}, {16'd0, cov[t0 + 11]});
        chk("stop_drop", {24'd0, drop_cnt}, 32'd0);
        step();
        chk("stop_keep", {16'd0, ifc.rnd_data}, {16'd0, cov[t0 + 11]});
        ifc.rnd_ready = 1'b1;
        step();
        chk("stop_popped", {31'd0, ifc.rnd_valid}, 32'd0);
        ifc.rnd_ready = 1'b0;

        // zero seed replaced, then stop during warm-up
        seed = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("zs_load", {31'd0, core_load}, 32'd1);
        chk("zs_seed", {16'd0, core_seed}, 32'hACE1);
        step();
        step();
        stop = 1'b1;
        chk("zs_warm_busy", {31'd0, busy}, 32'd1);
        step();
        stop = 1'b0;
        chk("zs_stop_busy", {31'd0, busy}, 32'd0);
        step();

        // overflow with stalled consumer
        seed = 16'($urandom);
        start = 1'b1;
        t0 = cyc;
        q.delete();
        drops = 0;
        for (int rel = 1; rel <= 610; rel++) begin
            step();
            if (rel == 1) start = 1'b0;
            if (rel == 8) begin
                chk("ovf_valid", {31'd0, ifc.rnd_valid}, 32'd1);
                chk("ovf_head", {16'd0, ifc.rnd_data}, {16'd0, q[0]});
            end
            if (rel == 12 || rel == 518 || rel == 520 || rel == 610)
                chk($sformatf("ovf_drop_%0d", rel), {24'd0, drop_cnt},
                    drops);
            if (rel >= 1 + W + D && ((rel - (1 + W + D)) % D) == 0) begin
                if (q.size() < 2) q.push_back(cov[cyc]);
                else if (drops < 255) drops++;
            end
        end
        chk("ovf_rd0", {16'd0, ifc.rnd_data}, {16'd0, q[0]});
        stop = 1'b1;
        ifc.rnd_ready = 1'b1;
        void'(q.pop_front());
        step();
        stop = 1'b0;
        chk("ovf_rd1_valid", {31'd0, ifc.rnd_valid}, 32'd1);
        chk("ovf_rd1", {16'd0, ifc.rnd_data}, {16'd0, q[0]});
        void'(q.pop_front());
        step();
        chk("ovf_empty", {31'd0, ifc.rnd_valid}, 32'd0);
        ifc.rnd_ready = 1'b0;

        // repetition fault on a stuck core
        hold = 1'b1;
        core_out = 16'hBEEF;
        seed = 16'h0F0F;
        start = 1'b1;
        for (int rel = 1; rel <= 14; rel++) begin
            step();
            if (rel == 1) start = 1'b0;
            if (rel == 10) begin
                chk("flt_valid", {31'd0, ifc.rnd_valid}, 32'd1);
                chk("flt_data", {16'd0, ifc.rnd_data}, 32'hBEEF);
            end
            if (rel == 11) chk("flt_pre", {31'd0, fault}, 32'd0);
            if (rel == 12) begin
                chk("flt_fault", {31'd0, fault}, 32'd1);
                chk("flt_flush", {31'd0, ifc.rnd_valid}, 32'd0);
                chk("flt_busy", {31'd0, busy}, 32'd1);
                stop = 1'b1;
            end
            if (rel == 13) begin
                stop = 1'b0;
                chk("flt_stop_ign", {31'd0, fault}, 32'd1);
                clr_fault = 1'b1;
            end
            if (rel == 14) begin
                clr_fault = 1'b0;
                chk("flt_clr", {31'd0, fault}, 32'd0);
                chk("flt_idle", {31'd0, busy}, 32'd0);
                chk("flt_drop_kept", {24'd0, drop_cnt}, 32'd255);
            end
        end
        hold = 1'b0;

        // asynchronous reset mid warm-up
        start = 1'b1;
        for (int rel = 1; rel <= 4; rel++) begin
            step();
            start = 1'b0;
        end
        #1 rst = 1'b1;
        #1 chk_reset_outputs("rst_warm");
        #2 rst = 1'b0;

        // asynchronous reset with a full buffer
        step();
        seed = 16'($urandom);
        start = 1'b1;
        for (int rel = 1; rel <= 12; rel++) begin
            step();
            start = 1'b0;
            if (rel == 10) chk("full_valid", {31'd0, ifc.rnd_valid}, 32'd1);
            if (rel == 12) chk("full_drop", {24'd0, drop_cnt}, 32'd1);
        end
        #1 rst = 1'b1;
        #1 chk_reset_outputs("rst_full");
        #2 rst = 1'b0;
        step();
        step();
        chk("post_rst_empty", {31'd0, ifc.rnd_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, miscmp);
        $finish;
    end

endmodule
